lib_onehot_serializer: RTL and testbench
========================================

LIB_ONEHOT_SERIALIZER -- requirements
Module: lib_onehot_serializer

Interface
REQ-001 Parameter LSB_MSB, default 0: extraction order; 0 = lowest set bit first, 1 = highest set bit first.
REQ-002 Parameter WIDTH, default 8: input vector width; legal range 2..64.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous to clk, active-high.
REQ-005 Port in_vect  input  WIDTH: multi-bit vector to decompose.
REQ-006 Port in_mask  input  WIDTH: bits set here are removed from in_vect at capture.
REQ-007 Port in_valid  input  1: in_vect/in_mask valid.
REQ-008 Port in_ready  output  1: block accepts input this cycle.
REQ-009 Port out_onehot  output  WIDTH: current one-hot item.
REQ-010 Port out_last  output  1: current item is the final one of the vector.
REQ-011 Port out_valid  output  1: out_onehot valid.
REQ-012 Port out_ready  input  1: downstream accepts out_onehot.
REQ-013 Port out_idx  output  $clog2(WIDTH): binary bit position of out_onehot (present only with LIB_ONEHOT_SER_INDEX_EN).

Function
REQ-014 States: IDLE, BUSY; state and a WIDTH-bit remainder register rem.
REQ-015 Input handshake when in_valid && in_ready; captured value = in_vect & ~in_mask.
REQ-016 IDLE: in_ready = 1, out_valid = 0; on handshake with nonzero captured value load rem and go BUSY; zero captured value is consumed and dropped, state stays IDLE.
REQ-017 BUSY: out_valid = 1, out_onehot = first set bit of rem per LSB_MSB, out_last = 1 iff rem has exactly one set bit.
REQ-018 Output handshake when out_valid && out_ready: rem <= rem ^ out_onehot next cycle.
REQ-019 Latency: first out_valid the cycle after input handshake; subsequent items one per cycle under continuous out_ready.
REQ-020 Output stable: out_onehot/out_last/out_idx unchanged while out_valid && !out_ready.
REQ-021 in_ready in BUSY = out_ready && out_last (back-to-back); simultaneous last-output and input handshake loads the new vector, stays BUSY if nonzero, else goes IDLE.
REQ-022 Last output handshake without new input handshake: BUSY -> IDLE.
REQ-023 Number of output items per vector = popcount of captured value; each set bit emitted exactly once, none invented.
REQ-024 out_valid, out_onehot, out_last, out_idx SHALL be zero whenever out_valid would be 0.

Reset
REQ-025 rst high: state = IDLE, rem = 0 at next edge; in-flight vector discarded, no further items.
REQ-026 During and after reset cycle: out_valid = 0, out_onehot = 0, out_last = 0, out_idx = 0, in_ready = 1 after release.

Configuration
REQ-027 Macro LIB_ONEHOT_SER_INDEX_EN defined: out_idx port present, combinational encode of out_onehot, same cycle.
REQ-028 Macro undefined: out_idx port and encoder absent; all other behaviour identical.

Structure
REQ-029 Package lib_onehot_ser_pkg holds the state enum (IDLE, BUSY) and index-width function for WIDTH.
REQ-030 Sub-module lib_ffs (LSB_MSB, WIDTH, base = 1) instantiated once on rem for first-set-bit selection.
REQ-031 No combinational path from in_valid to out_valid; in_ready combinationally depends only on state, out_ready, out_last.

Verification
REQ-032 WIDTH=8, LSB_MSB=0, in 0b1010_0110, out_ready=1 -> 0x02, 0x04, 0x20, 0x80 on 4 consecutive cycles, out_last on 0x80.
REQ-033 LSB_MSB=1, same vector -> 0x80, 0x20, 0x04, 0x02; out_idx 7,5,2,1 with LIB_ONEHOT_SER_INDEX_EN.
REQ-034 in 0xFF, in_mask 0xF0, out_ready toggling 1,0,1,0 -> 0x01, hold, 0x02, hold, ... 4 items, no drops or duplicates.
REQ-035 in 0x00 or in 0x0F with mask 0x0F -> accepted, no out_valid, in_ready remains 1.
REQ-036 Back-to-back 0x11 then 0x06 with in_valid held -> 0x01, 0x10, 0x02, 0x04 in 4 consecutive cycles, no bubble.
REQ-037 rst asserted mid-vector after 0x01 of 0x0F -> out_valid 0 next cycle, no further items; next vector 0x08 -> single item 0x08 with out_last.

Source files
------------

// File: rtl/lib_onehot_ser_pkg.sv
// Shared types and sizing helpers for the one-hot serializer.
// Optional index output is controlled by LIB_ONEHOT_SER_INDEX_EN in the top.
package lib_onehot_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int idx_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/lib_ffs.sv
// Find-first-set: isolates the first set bit of i_vect in the scan order chosen by LSB_MSB.
// BASE=1 returns the isolated bit; BASE=0 returns every scanned bit up to and including it.
module lib_ffs #(
    parameter int LSB_MSB = 0,
    parameter int WIDTH   = 8,
    parameter int BASE    = 1
) (
    input  logic [WIDTH-1:0] i_vect,
    output logic [WIDTH-1:0] o_sel
);

    logic w_found;

    always_comb begin
        w_found = 1'b0;
        o_sel   = '0;
        if (LSB_MSB == 0) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (!w_found) begin
                    if (i_vect[k]) begin
                        o_sel[k] = 1'b1;
                        w_found  = 1'b1;
                    end else if (BASE == 0) begin
                        o_sel[k] = 1'b1;
                    end
                end
            end
        end else begin
            for (int k = WIDTH - 1; k >= 0; k--) begin
                if (!w_found) begin
                    if (i_vect[k]) begin
                        o_sel[k] = 1'b1;
                        w_found  = 1'b1;
                    end else if (BASE == 0) begin
                        o_sel[k] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/lib_onehot_serializer.sv
// Splits a captured multi-bit vector into one-hot items, one per output handshake.
// Define LIB_ONEHOT_SER_INDEX_EN to add the out_idx binary position output.
module lib_onehot_serializer
    import lib_onehot_ser_pkg::*;
#(
    parameter  int LSB_MSB = 0,
    parameter  int WIDTH   = 8,
    localparam int IDX_W   = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_vect,
    input  logic [WIDTH-1:0] in_mask,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_last,
    output logic             out_valid,
`ifdef LIB_ONEHOT_SER_INDEX_EN
    output logic [IDX_W-1:0] out_idx,
`endif
    input  logic             out_ready
);

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;

    logic [WIDTH-1:0] w_cap;
    logic [WIDTH-1:0] w_first;
    logic             w_busy;
    logic             w_in_hs;
    logic             w_out_hs;

    lib_ffs #(
        .LSB_MSB (LSB_MSB),
        .WIDTH   (WIDTH),
        .BASE    (1)
    ) u_ffs (
        .i_vect (r_rem),
        .o_sel  (w_first)
    );

    assign w_cap = in_vect & ~in_mask;

    // Outputs are forced to zero while rst is high so nothing leaks during the reset cycle.
    assign w_busy     = (r_state == BUSY) && !rst;
    assign out_valid  = w_busy;
    assign out_onehot = w_busy ? w_first : '0;
    assign out_last   = w_busy && (r_rem == w_first);
    assign in_ready   = !w_busy || (out_ready && out_last);

    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else if (w_in_hs) begin
            // In BUSY this only happens together with the last output handshake.
            r_rem   <= w_cap;
            r_state <= (w_cap != '0) ? BUSY : IDLE;
        end else if (w_out_hs) begin
            r_rem <= r_rem ^ out_onehot;
            if (out_last) begin
                r_state <= IDLE;
            end
        end
    end

`ifdef LIB_ONEHOT_SER_INDEX_EN
    always_comb begin
        out_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (out_onehot[i]) begin
                out_idx = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_lib_onehot_serializer.sv
// Bench for lib_onehot_serializer: LSB-first and MSB-first instances share stimulus,
// each checked against a queue-of-items reference model.
module tb_lib_onehot_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] in_vect;
    logic [7:0] in_mask;
    logic       in_valid;
    logic       out_ready;

    logic       rdy0, rdy1;
    logic [7:0] oh0, oh1;
    logic       last0, last1;
    logic       vld0, vld1;
`ifdef LIB_ONEHOT_SER_INDEX_EN
    logic [2:0] idx0, idx1;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    lib_onehot_serializer #(.LSB_MSB(0), .WIDTH(8)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .in_vect    (in_vect),
        .in_mask    (in_mask),
        .in_valid   (in_valid),
        .in_ready   (rdy0),
        .out_onehot (oh0),
        .out_last   (last0),
        .out_valid  (vld0),
`ifdef LIB_ONEHOT_SER_INDEX_EN
        .out_idx    (idx0),
`endif
        .out_ready  (out_ready)
    );

    lib_onehot_serializer #(.LSB_MSB(1), .WIDTH(8)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .in_vect    (in_vect),
        .in_mask    (in_mask),
        .in_valid   (in_valid),
        .in_ready   (rdy1),
        .out_onehot (oh1),
        .out_last   (last1),
        .out_valid  (vld1),
`ifdef LIB_ONEHOT_SER_INDEX_EN
        .out_idx    (idx1),
`endif
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] pos_of(input logic [7:0] oh);
        logic [2:0] p;
        p = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) p = 3'(i);
        end
        return p;
    endfunction

    // Check current outputs against the model, then advance one clock and update the model.
    task automatic cycle();
        logic       e_valid;
        logic       e_last;
        logic       e_rdy;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] cap;
        #1;
        e_valid = !rst && (q0.size() != 0);
        e0      = e_valid ? q0[0] : 8'h00;
        e1      = e_valid ? q1[0] : 8'h00;
        e_last  = e_valid && (q0.size() == 1);
        e_rdy   = !e_valid || (out_ready && e_last);
        chk("lsb.out_valid",  vld0,  e_valid);
        chk("lsb.out_onehot", oh0,   e0);
        chk("lsb.out_last",   last0, e_last);
        chk("lsb.in_ready",   rdy0,  e_rdy);
        chk("msb.out_valid",  vld1,  e_valid);
        chk("msb.out_onehot", oh1,   e1);
        chk("msb.out_last",   last1, e_last);
        chk("msb.in_ready",   rdy1,  e_rdy);
`ifdef LIB_ONEHOT_SER_INDEX_EN
        chk("lsb.out_idx", idx0, pos_of(e0));
        chk("msb.out_idx", idx1, pos_of(e1));
`endif
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (e_valid && out_ready) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (in_valid && e_rdy) begin
                cap = in_vect & ~in_mask;
                q0.delete();
                q1.delete();
                for (int i = 0; i < 8; i++) begin
                    if (cap[i]) begin
                        q0.push_back(8'h01 << i);
                        q1.push_front(8'h01 << i);
                    end
                end
            end
        end
        #1;
    endtask

    task automatic drv(input logic [7:0] v, input logic [7:0] m, input logic iv,
                       input logic ordy, input logic r);
        in_vect   = v;
        in_mask   = m;
        in_valid  = iv;
        out_ready = ordy;
        rst       = r;
        cycle();
    endtask

    initial begin
        in_vect = '0; in_mask = '0; in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;

        drv(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        drv(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        drv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // 0b1010_0110 streamed with out_ready held high
        drv(8'hA6, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (5) drv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Masked vector with back-pressure on alternate cycles
        drv(8'hFF, 8'hF0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) drv(8'h00, 8'h00, 1'b0, (k % 2) == 0, 1'b0);

        // Zero captured values are swallowed
        drv(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        drv(8'h0F, 8'h0F, 1'b1, 1'b1, 1'b0);
        repeat (2) drv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Back-to-back vectors with in_valid held
        drv(8'h11, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (2) drv(8'h06, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (3) drv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset mid-vector, then a single-bit vector
        drv(8'h0F, 8'h00, 1'b1, 1'b1, 1'b0);
        drv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        drv(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        repeat (2) drv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        drv(8'h08, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (2) drv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drv(8'($urandom),
                ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 40) == 0);
        end
        repeat (10) drv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
